// File: rtl/ikbd_bridge_pkg.sv
// ikbd_bridge_pkg -- shared defaults and types for the IKBD byte bridge.
//   RX_DEPTH_DEF / TX_DEPTH_DEF : default FIFO depths
//   byte_t                      : one serial byte
package ikbd_bridge_pkg;

    localparam int RX_DEPTH_DEF = 16;
    localparam int TX_DEPTH_DEF = 8;

    typedef logic [7:0] byte_t;

endpackage

// File: rtl/ikbd_bridge_if.sv
// ikbd_bridge_if -- bundle of the user_io (SPI side) and ACIA side signals.
//   slave  : seen by the bridge (strobes/data/ready in, FIFO state out)
//   master : seen by the surrounding logic / testbench
//   rx_* : IO controller -> ACIA path, tx_* : ACIA -> IO controller path
//   tx_level is an extra occupancy readout of the transmit FIFO.
interface ikbd_bridge_if
    import ikbd_bridge_pkg::*;
#(
    parameter int RX_DEPTH = RX_DEPTH_DEF,
    parameter int TX_DEPTH = TX_DEPTH_DEF
);
    localparam int RX_LW = $clog2(RX_DEPTH) + 1;
    localparam int TX_LW = $clog2(TX_DEPTH) + 1;

    logic             rx_strobe_in;
    byte_t            rx_data_in;
    logic             rx_valid;
    byte_t            rx_data;
    logic             rx_ready;
    logic [RX_LW-1:0] rx_level;
    logic             rx_overflow;
    logic             clr_overflow;

    logic             tx_valid;
    byte_t            tx_data;
    logic             tx_ready;
    logic             tx_available;
    byte_t            tx_data_out;
    logic             tx_strobe;
    logic [TX_LW-1:0] tx_level;

    modport slave (
        input  rx_strobe_in, rx_data_in, rx_ready, clr_overflow,
        input  tx_valid, tx_data, tx_strobe,
        output rx_valid, rx_data, rx_level, rx_overflow,
        output tx_ready, tx_available, tx_data_out, tx_level
    );

    modport master (
        output rx_strobe_in, rx_data_in, rx_ready, clr_overflow,
        output tx_valid, tx_data, tx_strobe,
        input  rx_valid, rx_data, rx_level, rx_overflow,
        input  tx_ready, tx_available, tx_data_out, tx_level
    );

endinterface

// File: rtl/ikbd_bridge_fifo.sv
// byte_fifo -- synchronous byte FIFO, power-of-two depth.
//   i_clk, i_reset : clock, synchronous active-high reset (flushes pointers)
//   i_push, i_data : write request; dropped when full unless a pop is
//                    performed in the same cycle
//   i_pop          : read request; ignored when empty
//   o_data         : head byte, forced to 0 while empty
//   o_level        : occupancy 0..DEPTH
//   o_full, o_empty: occupancy flags
module byte_fifo
    import ikbd_bridge_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_push,
    input  logic          i_pop,
    input  byte_t         i_data,
    output byte_t         o_data,
    output logic [LW-1:0] o_level,
    output logic          o_full,
    output logic          o_empty
);

    byte_t         r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;

    logic w_pop;
    logic w_push;

    assign o_full  = (r_level == LW'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    // Gate the head so stale memory never shows once the FIFO is drained or flushed.
    assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

    assign w_pop  = i_pop && !o_empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            // Pointers are AW bits wide, so the increment wraps modulo DEPTH.
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/ikbd_bridge.sv
// ikbd_bridge -- byte bridge between the SPI user_io block and the IKBD ACIA.
//   clk, reset : core clock, synchronous active-high reset
//   bus        : ikbd_bridge_if.slave
//     rx path  : rx_strobe_in/rx_data_in (async) -> receive FIFO ->
//                rx_valid/rx_data/rx_ready, rx_level, sticky rx_overflow
//     tx path  : tx_valid/tx_data/tx_ready -> transmit FIFO ->
//                tx_available/tx_data_out, popped on tx_strobe rising edge
module ikbd_bridge
    import ikbd_bridge_pkg::*;
#(
    parameter int RX_DEPTH = RX_DEPTH_DEF,
    parameter int TX_DEPTH = TX_DEPTH_DEF
) (
    input  logic               clk,
    input  logic               reset,
    ikbd_bridge_if.slave       bus
);

    // [0] first sync flop, [1] second sync flop, [2] history flop.
    // Reset to all ones so a strobe already high at reset release is not an edge.
    logic [2:0] r_rx_sync;
    logic [2:0] r_tx_sync;
    logic       w_rx_edge;
    logic       w_tx_edge;

    logic       r_rx_push;
    byte_t      r_rx_byte;
    logic       r_rx_overflow;

    logic       w_rx_pop;
    logic       w_rx_full;
    logic       w_rx_empty;
    logic       w_rx_drop;
    logic       w_tx_push;
    logic       w_tx_full;
    logic       w_tx_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_sync <= 3'b111;
            r_tx_sync <= 3'b111;
        end else begin
            r_rx_sync <= {r_rx_sync[1:0], bus.rx_strobe_in};
            r_tx_sync <= {r_tx_sync[1:0], bus.tx_strobe};
        end
    end

    assign w_rx_edge = r_rx_sync[1] && !r_rx_sync[2];
    assign w_tx_edge = r_tx_sync[1] && !r_tx_sync[2];

    // The byte is latched in the edge cycle and written one cycle later; this
    // stage keeps the FIFO write port off the synchroniser timing path.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_push <= 1'b0;
            r_rx_byte <= '0;
        end else begin
            r_rx_push <= w_rx_edge;
            if (w_rx_edge) r_rx_byte <= bus.rx_data_in;
        end
    end

    assign w_rx_pop  = !w_rx_empty && bus.rx_ready;
    assign w_rx_drop = r_rx_push && w_rx_full && !w_rx_pop;

    // Set has priority over clear so a coincident overflow is never lost.
    always_ff @(posedge clk) begin
        if (reset)                 r_rx_overflow <= 1'b0;
        else if (w_rx_drop)        r_rx_overflow <= 1'b1;
        else if (bus.clr_overflow) r_rx_overflow <= 1'b0;
    end

    byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .i_clk   (clk),
        .i_reset (reset),
        .i_push  (r_rx_push),
        .i_pop   (w_rx_pop),
        .i_data  (r_rx_byte),
        .o_data  (bus.rx_data),
        .o_level (bus.rx_level),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty)
    );

    assign bus.rx_valid    = !w_rx_empty;
    assign bus.rx_overflow = r_rx_overflow;

    assign w_tx_push = bus.tx_valid && !w_tx_full;

    // An edge on an empty FIFO is a no-op inside byte_fifo.
    byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .i_clk   (clk),
        .i_reset (reset),
        .i_push  (w_tx_push),
        .i_pop   (w_tx_edge),
        .i_data  (bus.tx_data),
        .o_data  (bus.tx_data_out),
        .o_level (bus.tx_level),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty)
    );

    assign bus.tx_ready     = !w_tx_full;
    assign bus.tx_available = !w_tx_empty;

endmodule

// File: doc/ikbd_bridge.md
IKBD_BRIDGE -- requirements
Module: ikbd_bridge

Interface
REQ-001 Parameter RX_DEPTH, default 16: entries in the receive FIFO (IO controller to ACIA); power of two, 4..64.
REQ-002 Parameter TX_DEPTH, default 8: entries in the transmit FIFO (ACIA to IO controller); power of two, 4..64.
REQ-003 clk  in  1  core clock; all logic in this single domain.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 rx_strobe_in  in  1  byte strobe from SPI user_io, asynchronous to clk, high for at least 8 SPI clocks.
REQ-006 rx_data_in  in  8  byte from user_io; stable while rx_strobe_in is high.
REQ-007 rx_valid  out  1  receive FIFO head valid toward ACIA.
REQ-008 rx_data  out  8  receive FIFO head byte.
REQ-009 rx_ready  in  1  ACIA accepts head; pop when rx_valid && rx_ready.
REQ-010 rx_level  out  clog2(RX_DEPTH)+1  receive FIFO occupancy.
REQ-011 rx_overflow  out  1  sticky: byte dropped on full receive FIFO.
REQ-012 clr_overflow  in  1  clears rx_overflow.
REQ-013 tx_valid  in  1  ACIA offers byte.
REQ-014 tx_data  in  8  ACIA byte.
REQ-015 tx_ready  out  1  transmit FIFO not full; push when tx_valid && tx_ready.
REQ-016 tx_available  out  1  to user_io data_out_available; transmit FIFO non-empty.
REQ-017 tx_data_out  out  8  to user_io data_out; transmit FIFO head.
REQ-018 tx_strobe  in  1  from user_io strobe_out, asynchronous; rising edge = head consumed.

Function
REQ-019 rx_strobe_in and tx_strobe each pass through a 2-flop synchroniser plus one history flop; rising edge = sync high && history low.
REQ-020 On an rx edge, rx_data_in is captured in the same clock cycle and pushed; the byte is visible on rx_valid/rx_data 3 clk cycles after the strobe is first sampled high.
REQ-021 rx push when full and no pop in the same cycle: byte dropped, rx_overflow set next cycle, FIFO contents unchanged.
REQ-022 rx push and pop in the same cycle while full: both performed, no overflow, level unchanged.
REQ-023 clr_overflow coinciding with a new overflow: set wins.
REQ-024 rx_data is valid only while rx_valid is high; the head does not change except on a pop.
REQ-025 On a tx edge with the transmit FIFO non-empty: pop; tx_available/tx_data_out update next cycle. On a tx edge while empty: ignore, no state change.
REQ-026 tx_data_out holds the head byte from push until the tx edge that pops it, across any number of SPI polls.
REQ-027 tx push and tx pop in the same cycle are both performed; tx_ready = !full (combinational from registered state).
REQ-028 Pointers wrap modulo depth; level ranges 0..DEPTH; full = level==DEPTH.

Reset
REQ-029 Reset flushes both FIFOs: rx_valid=0, rx_level=0, tx_available=0, tx_ready=1, rx_overflow=0; rx_data and tx_data_out read 0.
REQ-030 Synchroniser and history flops reset to 1, so a strobe held high through reset release produces no edge.
REQ-031 Reset mid-transfer discards all buffered bytes and any edge in flight; the first edge after reset requires the strobe to be sampled low, then high.

Structure
REQ-032 ikbd_bridge_pkg holds RX_DEPTH/TX_DEPTH defaults and the byte type.
REQ-033 One sub-module, byte_fifo (parameterised depth, push/pop/level/full/empty), instantiated twice; the synchronisers stay inline.

Verification
REQ-034 Strobe pulse with rx_data_in=8'hA5, rx_ready=0 -> rx_valid=1, rx_data=8'hA5 exactly 3 clk after first high sample; rx_level=1.
REQ-035 17 strobes, rx_ready=0 -> rx_level=16, rx_overflow=1, bytes 1..16 drained in order; clr_overflow -> rx_overflow=0.
REQ-036 Full rx FIFO, rx_ready=1 in the cycle of the 17th edge -> no overflow, level stays 16.
REQ-037 ACIA pushes 8'h12, 8'h34 -> tx_available=1, tx_data_out=8'h12; one tx_strobe pulse -> tx_data_out=8'h34; second pulse -> tx_available=0; third pulse -> no change.
REQ-038 Strobe held high across reset release -> no push; subsequent low-high pulse with 8'h5A -> single entry 8'h5A.
REQ-039 9 tx pushes with no strobes -> tx_ready=0 after the 8th; 9th held until a strobe pops.
